double_mat_conv_check: RTL and testbench
========================================

DOUBLE_MAT_CONV_CHECK -- requirements
Module: double_mat_conv_check

Interface
REQ-001 SHALL have parameter SIZE_A, default 8, matrix row count (>=1).
REQ-002 SHALL have parameter SIZE_B, default 8, matrix column count (>=1).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a scan.
REQ-006 SHALL have port mat_in  input  double[SIZE_A][SIZE_B]  difference matrix from the upstream subtract stage, IEEE-754 binary64.
REQ-007 SHALL have port thr  input  double  convergence threshold, positive.
REQ-008 SHALL have port busy  output  1  scan in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-010 SHALL have port converged  output  1  all element magnitudes below thr.
REQ-011 SHALL have port max_abs  output  double  largest element magnitude, sign bit 0.
REQ-012 SHALL have port max_row  output  max(1,$clog2(SIZE_A))  row index of max_abs.
REQ-013 SHALL have port max_col  output  max(1,$clog2(SIZE_B))  column index of max_abs.
REQ-014 SHALL have port nan_found  output  1  present only with DOUBLE_CONV_NAN_EN.

Function
REQ-015 SHALL implement FSM IDLE -> SCAN -> DONE -> IDLE; busy=1 exactly in SCAN.
REQ-016 SHALL leave IDLE for SCAN on the edge sampling start=1; start outside IDLE is ignored.
REQ-017 SHALL register thr on that edge; later thr changes do not affect the scan.
REQ-018 SHALL clear the running maximum to +0.0 and the indices to 0 on that edge.
REQ-019 SHALL evaluate one element per cycle in SCAN, row-major (0,0),(0,1)...(SIZE_A-1,SIZE_B-1), N=SIZE_A*SIZE_B cycles.
REQ-020 SHALL require mat_in stable while busy=1; no internal copy of the matrix is taken.
REQ-021 SHALL form magnitude as bits[62:0] with bit 63 forced 0; -0.0 equals +0.0.
REQ-022 SHALL compare magnitudes as unsigned 63-bit integers; no FP core is used.
REQ-023 SHALL replace the running maximum only when strictly greater; ties keep the earliest index.
REQ-024 SHALL enter DONE after element N-1; done=1 for exactly one cycle, N+1 edges after the start edge.
REQ-025 SHALL set converged=1 iff max_abs < thr (strict, unsigned magnitude compare), updated with done.
REQ-026 SHALL hold converged, max_abs, max_row and max_col from done until the next accepted start.
REQ-027 SHALL accept start in the cycle immediately after done (back-to-back scans).
REQ-028 SHALL handle SIZE_A=SIZE_B=1: done two edges after start.
REQ-029 SHALL rank +Inf above all finite values; converged=0 if any element is Inf.

Reset
REQ-030 SHALL on rst=1 immediately force IDLE and busy=0, done=0, converged=0, max_abs=+0.0, max_row=0, max_col=0, nan_found=0.
REQ-031 SHALL abort a scan in progress on reset; no done pulse for the aborted scan.
REQ-032 SHALL ignore start while rst=1; first start accepted on the first edge after release.

Configuration
REQ-033 SHALL use macro DOUBLE_CONV_NAN_EN to compile NaN screening in or out.
REQ-034 SHALL with DOUBLE_CONV_NAN_EN: exclude NaN elements (exp all ones, mantissa nonzero) from the maximum, set nan_found=1 at done if any seen, force converged=0.
REQ-035 SHALL without DOUBLE_CONV_NAN_EN: have no nan_found port; NaN magnitudes compare as integers and win over +Inf.

Verification
REQ-036 SHALL cover: all elements +0.0, thr=0x3EB0C6F7A0B5ED8D (1e-6) -> done at start+N+1, converged=1, max_abs=0, indices (0,0).
REQ-037 SHALL cover: element (3,5)=0xBFF0000000000000 (-1.0), rest 1e-9, thr=1e-6 -> max_abs=0x3FF0000000000000, max_row=3, max_col=5, converged=0.
REQ-038 SHALL cover: elements (1,1) and (6,2) both 2.0, rest 0 -> max_row=1, max_col=1 (earliest tie).
REQ-039 SHALL cover: element equal to thr exactly (1e-6), rest 0 -> converged=0.
REQ-040 SHALL cover: rst pulsed at scan cycle 20, then start -> no done for first scan, second done at start+N+1.
REQ-041 SHALL cover: with macro, element (0,7)=0x7FF8000000000000, rest 0.5 -> nan_found=1, converged=0, max_abs=0x3FE0000000000000.

Source files
------------

// File: rtl/double_mat_conv_check.sv
// Sequential max-magnitude / convergence check over a binary64 difference matrix.
// Optional NaN screening is compiled in with `define DOUBLE_CONV_NAN_EN.
module double_mat_conv_check #(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  localparam int RW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1,
  localparam int CW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [SIZE_A-1:0][SIZE_B-1:0][63:0]  mat_in,
  input  logic [63:0]                          thr,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 converged,
  output logic [63:0]                          max_abs,
  output logic [RW-1:0]                        max_row,
  output logic [CW-1:0]                        max_col
`ifdef DOUBLE_CONV_NAN_EN
  ,
  output logic                                 nan_found
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [RW-1:0] LAST_ROW = RW'(SIZE_A - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(SIZE_B - 1);

  state_t        state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [63:0]   thr_q;
  logic          nan_seen;

  logic [63:0] elem;
  logic [62:0] mag;
  logic        elem_nan;
  logic        greater;
  logic        last_elem;

  // Magnitude is the raw bit pattern with the sign dropped, so an integer
  // compare orders non-negative doubles correctly and -0.0 equals +0.0.
  assign elem      = mat_in[row][col];
  assign mag       = elem[62:0];
  assign elem_nan  = (&elem[62:52]) && (|elem[51:0]);
  assign greater   = mag > max_abs[62:0];
  assign last_elem = (row == LAST_ROW) && (col == LAST_COL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      thr_q     <= '0;
      nan_seen  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      converged <= 1'b0;
      max_abs   <= '0;
      max_row   <= '0;
      max_col   <= '0;
`ifdef DOUBLE_CONV_NAN_EN
      nan_found <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= SCAN;
            busy     <= 1'b1;
            thr_q    <= thr;
            max_abs  <= '0;
            max_row  <= '0;
            max_col  <= '0;
            row      <= '0;
            col      <= '0;
            nan_seen <= 1'b0;
          end
        end
        SCAN: begin
`ifdef DOUBLE_CONV_NAN_EN
          if (elem_nan) begin
            nan_seen <= 1'b1;
          end else if (greater) begin
            max_abs <= {1'b0, mag};
            max_row <= row;
            max_col <= col;
          end
`else
          if (greater) begin
            max_abs <= {1'b0, mag};
            max_row <= row;
            max_col <= col;
          end
`endif
          if (col == LAST_COL) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
          if (last_elem) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        // Extra cycle lets the convergence compare see the final maximum.
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
`ifdef DOUBLE_CONV_NAN_EN
          converged <= (max_abs[62:0] < thr_q[62:0]) && !nan_seen;
          nan_found <= nan_seen;
`else
          converged <= max_abs[62:0] < thr_q[62:0];
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  logic unused_nan;
  assign unused_nan = elem_nan ^ nan_seen;

endmodule

// File: tb/tb_double_mat_conv_check.sv
// Scoreboard bench for double_mat_conv_check: directed matrices, expected results
// queued at start, monitor compares on every done pulse.
module tb_double_mat_conv_check;

  localparam int SA = 8;
  localparam int SB = 8;
  localparam int N  = SA * SB;

  localparam logic [63:0] THR_1EM6 = 64'h3EB0C6F7A0B5ED8D;
  localparam logic [63:0] ONE      = 64'h3FF0000000000000;
  localparam logic [63:0] NEG_ONE  = 64'hBFF0000000000000;
  localparam logic [63:0] TWO      = 64'h4000000000000000;
  localparam logic [63:0] HALF     = 64'h3FE0000000000000;
  localparam logic [63:0] P_1EM9   = 64'h3E112E0BE826D695;
  localparam logic [63:0] N_1EM9   = 64'hBE112E0BE826D695;
  localparam logic [63:0] NEG_ZERO = 64'h8000000000000000;
  localparam logic [63:0] P_INF    = 64'h7FF0000000000000;
  localparam logic [63:0] QNAN     = 64'h7FF8000000000000;

  typedef logic [SA-1:0][SB-1:0][63:0] mat_t;

  typedef struct {
    logic [63:0] max_abs;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        conv;
    logic        nan;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  mat_t        mat_in;
  logic [63:0] thr;
  logic        busy;
  logic        done;
  logic        converged;
  logic [63:0] max_abs;
  logic [2:0]  max_row;
  logic [2:0]  max_col;
`ifdef DOUBLE_CONV_NAN_EN
  logic        nan_found;
`endif

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   done_seen = 0;

  double_mat_conv_check #(.SIZE_A(SA), .SIZE_B(SB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mat_in    (mat_in),
    .thr       (thr),
    .busy      (busy),
    .done      (done),
    .converged (converged),
    .max_abs   (max_abs),
    .max_row   (max_row),
`ifdef DOUBLE_CONV_NAN_EN
    .max_col   (max_col),
    .nan_found (nan_found)
`else
    .max_col   (max_col)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkValue("done_cycle", 64'(cyc), 64'(e.done_cyc));
    checkValue("max_abs", max_abs, e.max_abs);
    checkValue("max_row", 64'(max_row), 64'(e.row));
    checkValue("max_col", 64'(max_col), 64'(e.col));
    checkValue("converged", 64'(converged), 64'(e.conv));
`ifdef DOUBLE_CONV_NAN_EN
    checkValue("nan_found", 64'(nan_found), 64'(e.nan));
`endif
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_seen++;
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, required no pending scan", cyc);
      end else begin
        checkOutput(sb_q.pop_front());
      end
    end
  end

  function automatic mat_t fillMat(input logic [63:0] v);
    mat_t m;
    for (int i = 0; i < SA; i++)
      for (int j = 0; j < SB; j++)
        m[i][j] = v;
    return m;
  endfunction

  function automatic exp_t mkExp(input logic [63:0] mx, input int r, input int c,
                                 input logic cv, input logic nf);
    exp_t e;
    e.max_abs  = mx;
    e.row      = 3'(r);
    e.col      = 3'(c);
    e.conv     = cv;
    e.nan      = nf;
    e.done_cyc = 0;
    return e;
  endfunction

  // Issues a start from a negedge; thr is scrambled afterwards to prove it was captured.
  task automatic applyStimulus(input mat_t m, input logic [63:0] t, input exp_t e);
    mat_in = m;
    thr    = t;
    start  = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    thr        = 64'h0;
    e.done_cyc = cyc + N + 1;
    sb_q.push_back(e);
    checkValue("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic waitDone(input string name);
    int k;
    for (k = 0; k < N + 20; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == N + 20) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s_timeout: got no done within %0d cycles, required done", name, N + 20);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mat_t m;
    int   done_before;
    rst    = 1'b1;
    start  = 1'b0;
    mat_in = fillMat(64'h0);
    thr    = 64'h0;
    repeat (2) @(negedge clk);
    checkValue("reset_busy", 64'(busy), 64'd0);
    checkValue("reset_done", 64'(done), 64'd0);
    checkValue("reset_converged", 64'(converged), 64'd0);
    checkValue("reset_max_abs", max_abs, 64'h0);
    checkValue("reset_max_row", 64'(max_row), 64'd0);
    checkValue("reset_max_col", 64'(max_col), 64'd0);
`ifdef DOUBLE_CONV_NAN_EN
    checkValue("reset_nan_found", 64'(nan_found), 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(fillMat(64'h0), THR_1EM6, mkExp(64'h0, 0, 0, 1'b1, 1'b0));
    waitDone("all_zero");

    // From here on each start lands in the cycle right after the previous done.
    m = fillMat(P_1EM9);
    m[3][5] = NEG_ONE;
    applyStimulus(m, THR_1EM6, mkExp(ONE, 3, 5, 1'b0, 1'b0));
    waitDone("neg_one");

    m = fillMat(64'h0);
    m[1][1] = TWO;
    m[6][2] = TWO;
    applyStimulus(m, THR_1EM6, mkExp(TWO, 1, 1, 1'b0, 1'b0));
    waitDone("tie");

    m = fillMat(64'h0);
    m[4][4] = THR_1EM6;
    applyStimulus(m, THR_1EM6, mkExp(THR_1EM6, 4, 4, 1'b0, 1'b0));
    waitDone("equal_thr");

    m = fillMat(NEG_ZERO);
    m[7][7] = N_1EM9;
    applyStimulus(m, THR_1EM6, mkExp(P_1EM9, 7, 7, 1'b1, 1'b0));
    waitDone("neg_zero_last");

    m = fillMat(ONE);
    m[2][3] = P_INF;
    applyStimulus(m, THR_1EM6, mkExp(P_INF, 2, 3, 1'b0, 1'b0));
    waitDone("inf");

    m = fillMat(HALF);
    m[0][7] = QNAN;
`ifdef DOUBLE_CONV_NAN_EN
    applyStimulus(m, ONE, mkExp(HALF, 0, 0, 1'b0, 1'b1));
`else
    applyStimulus(m, ONE, mkExp(QNAN, 0, 7, 1'b0, 1'b0));
`endif
    waitDone("nan");

    // Abort a scan mid-way with reset, holding start high through the reset.
    @(negedge clk);
    applyStimulus(fillMat(P_1EM9), THR_1EM6, mkExp(64'h0, 0, 0, 1'b1, 1'b0));
    repeat (19) @(negedge clk);
    done_before = done_seen;
    m = fillMat(64'h0);
    m[5][0] = HALF;
    mat_in = m;
    thr    = ONE;
    rst    = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    checkValue("abort_busy", 64'(busy), 64'd0);
    checkValue("abort_done", 64'(done), 64'd0);
    checkValue("abort_max_abs", max_abs, 64'h0);
    sb_q.delete();
    rst = 1'b0;
    applyStimulus(m, ONE, mkExp(HALF, 5, 0, 1'b1, 1'b0));
    waitDone("after_reset");
    @(negedge clk);
    checkValue("done_pulses_after_abort", 64'(done_seen - done_before), 64'd1);

    repeat (3) @(negedge clk);
    checkValue("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
